tff_count_sequencer: RTL and testbench

- Controller that sequences a WIDTH-bit bank of toggle flip-flops as a modulo-N up/down counter.
- Each cycle it computes the next count and drives a per-bit toggle mask, so an external T-flip-flop bank clocked on the same edge tracks `count` exactly.
- Handles start/stop/pause, one-shot vs. free-running mode, and terminal-count/wrap signalling for the surrounding counter lab datapath.

---
 rtl/tff_count_sequencer.sv | 88 ++++++++
 tb/tb_tff_count_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer: modulo-N up/down count controller emitting a per-bit toggle mask
// so an external T flip-flop bank clocked on the same edge tracks count.
module tff_count_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             up_dn,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             wrap,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] count_next, limit_q, step;
    logic             up_q, os_q, at_term, latch, wrap_next, done_next;

    always_comb begin
        at_term    = up_q ? (count == limit_q) : (count == '0);
        step       = up_q ? (at_term ? '0 : count + 1'b1) : (at_term ? limit_q : count - 1'b1);
        state_next = state;
        count_next = count;
        latch      = 1'b0;
        wrap_next  = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: if (start) begin
                latch      = 1'b1;
                count_next = up_dn ? '0 : limit;
                state_next = RUN;
            end
            RUN: if (stop) begin
                count_next = '0;
                state_next = IDLE;
            end else if (pause) begin
                state_next = PAUSE;
            end else if (at_term && os_q) begin
                state_next = DONE;
                done_next  = 1'b1;
            end else begin
                count_next = step;
                wrap_next  = at_term;
            end
            // Leaving PAUSE only re-enters RUN; the count advances on the next edge.
            PAUSE: if (stop) begin
                count_next = '0;
                state_next = IDLE;
            end else if (!pause) begin
                state_next = RUN;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign t_vec = count ^ count_next;
    assign busy  = (state == RUN) || (state == PAUSE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            limit_q <= '0;
            up_q    <= 1'b1;
            os_q    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            wrap  <= wrap_next;
            done  <= done_next;
            if (latch) begin
                limit_q <= limit;
                up_q    <= up_dn;
                os_q    <= one_shot;
            end
        end
    end
endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb_tff_count_sequencer: vector table, directed corner sequences and a randomized
// run against a rule-level model, with an external TFF bank driven by t_vec.
module tb_tff_count_sequencer;
    logic       clk = 1'b0, reset = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, up_dn = 1'b0, one_shot = 1'b0;
    logic [2:0] limit = 3'd0;
    logic [2:0] count, t_vec, bank, tv;
    logic       busy, wrap, done;
    int         total = 0, passed = 0;

    always #5 clk = ~clk;

    tff_count_sequencer #(.WIDTH(3)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .up_dn(up_dn), .one_shot(one_shot), .limit(limit),
        .count(count), .t_vec(t_vec), .busy(busy), .wrap(wrap), .done(done)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) bank <= 3'd0;
        else bank <= bank ^ t_vec;

    typedef struct {
        logic       st, sp, ps, ud, os;
        logic [2:0] lim, t, cnt;
        logic       bsy, wr, dn;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t v(input logic st, sp, ps, ud, os, input logic [2:0] lim, t, cnt,
                               input logic bsy, wr, dn);
        v = '{st, sp, ps, ud, os, lim, t, cnt, bsy, wr, dn};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Called just after a falling edge: apply inputs, capture t_vec, cross one rising edge.
    task automatic drive(input logic st, sp, ps, ud, os, input logic [2:0] lim);
        start = st; stop = sp; pause = ps; up_dn = ud; one_shot = os; limit = lim;
        #1 tv = t_vec;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic outs(input string tag, input int c, input int b, input int w, input int d);
        chk({tag, " count"}, count, c);
        chk({tag, " busy"}, busy, b);
        chk({tag, " wrap"}, wrap, w);
        chk({tag, " done"}, done, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ms, mc, ml, mu, mo, mw, md, ns, nc;
        logic st, sp, ps, ud, os;
        logic [2:0] lim;
        tbl[0]  = v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        tbl[1]  = v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0);
        tbl[2]  = v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0);
        tbl[3]  = v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0);
        tbl[4]  = v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd7, 3'd4, 1'b1, 1'b0, 1'b0);
        tbl[5]  = v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd1, 3'd5, 1'b1, 1'b0, 1'b0);
        tbl[6]  = v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd5, 3'd0, 1'b1, 1'b1, 1'b0);
        tbl[7]  = v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0);
        tbl[8]  = v(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        tbl[9]  = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 3'd4, 1'b1, 1'b0, 1'b0);
        tbl[10] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd7, 3'd3, 1'b1, 1'b0, 1'b0);
        tbl[11] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0);
        tbl[12] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0);
        tbl[13] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0);
        tbl[14] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        tbl[15] = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tbl[16] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        #12;
        outs("reset", 0, 0, 0, 0);
        chk("reset t_vec", t_vec, 0);
        @(negedge clk) reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].ps, tbl[i].ud, tbl[i].os, tbl[i].lim);
            chk($sformatf("vec%0d t_vec", i), tv, tbl[i].t);
            outs($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].bsy, tbl[i].wr, tbl[i].dn);
            chk($sformatf("vec%0d bank", i), bank, count);
        end

        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
        chk("pause pre count", count, 2);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7);
            chk($sformatf("pause%0d t_vec", k), tv, 0);
            outs($sformatf("pause%0d", k), 2, 1, 0, 0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
        chk("dead t_vec", tv, 0);
        outs("dead", 2, 1, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
        chk("resume t_vec", tv, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
        chk("resume count", count, 4);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7);
        chk("stop t_vec", tv, 4);
        outs("stop", 0, 0, 0, 0);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
        for (int k = 0; k < 6; k++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
        chk("pre-reset count", count, 6);
        #2 reset = 1'b0;
        #1;
        chk("async count", count, 0);
        chk("async busy", busy, 0);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outs("held reset", 0, 0, 0, 0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
        outs("post reset", 0, 0, 0, 0);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        outs("lim0 os load", 0, 1, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        chk("lim0 os t_vec", tv, 0);
        outs("lim0 os done", 0, 0, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        outs("lim0 os idle", 0, 0, 0, 0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        outs("lim0 free wrap", 0, 1, 1, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("lim0 free t_vec", tv, 0);
        chk("lim0 free wrap2", wrap, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        outs("lim0 free stop", 0, 0, 0, 0);

        reset = 1'b0;
        #1 reset = 1'b1;
        ms = 0; mc = 0; ml = 0; mu = 1; mo = 0;
        for (int n = 0; n < 300; n++) begin
            st = ($urandom_range(0, 2) == 0);
            sp = ($urandom_range(0, 9) == 0);
            ps = ($urandom_range(0, 3) == 0);
            ud = 1'($urandom_range(0, 1));
            os = ($urandom_range(0, 3) == 0);
            lim = 3'($urandom_range(0, 7));
            ns = ms; nc = mc; mw = 0; md = 0;
            if (ms == 0) begin
                if (st) begin
                    ml = lim; mu = ud; mo = os;
                    nc = ud ? 0 : lim;
                    ns = 1;
                end
            end else if (ms == 3) ns = 0;
            else if (sp) begin
                nc = 0; ns = 0;
            end else if (ms == 2) ns = ps ? 2 : 1;
            else if (ps) ns = 2;
            else if (mc == (mu ? ml : 0) && mo) begin
                ns = 3; md = 1;
            end else begin
                mw = (mc == (mu ? ml : 0));
                nc = mu ? (mc + 1) % (ml + 1) : (mc + ml) % (ml + 1);
            end
            drive(st, sp, ps, ud, os, lim);
            chk("rand t_vec", tv, mc ^ nc);
            ms = ns; mc = nc;
            outs("rand", mc, (ms == 1 || ms == 2), mw, md);
            chk("rand bank", bank, count);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
